uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

UART transmit serializer that sits directly downstream of the UART control register block. It consumes the frame configuration from that block (word length, stop-bit count, oversampling mode) plus a parallel data word handed over with a valid/ready handshake. It emits an asynchronous serial frame on `txd`: start bit, LSB-first data, and one or two stop bits. Bit periods are derived from an external oversample tick.

## Interface
- `DATA_W`, default 16: width of `tx_data`; maximum supported data bits per frame.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous active-low reset.
- `tick`  input  1  single-cycle oversample enable (16x or 3x the baud rate).
- `word_length`  input  5  data bits per frame, from the control register.
- `Num_stop_bits`  input  1  0 = one stop bit, 1 = two stop bits.
- `oversample_by_3`  input  1  0 = 16 ticks per bit, 1 = 3 ticks per bit.
- `tx_valid`  input  1  `tx_data` holds a word to send.
- `tx_data`  input  DATA_W  word to send; bit 0 is transmitted first.
- `tx_ready`  output  1  block can accept a word this cycle.
- `txd`  output  1  serial line, idle high.
- `busy`  output  1  a frame is in progress.
- `frame_done`  output  1  one-cycle pulse when the last stop bit completes.

## Operation
- One clock (`clk`); reset is asynchronous and active-low (`reset_n`).
- Reset values: `txd`=1, `tx_ready`=1, `busy`=0, `frame_done`=0, state=IDLE, all counters 0.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - `tx_ready`=1 and `txd`=1.
  - On `tx_valid & tx_ready`, latch `tx_data`, latch the configuration, then go to START.
- Configuration is latched only at acceptance. Changes to `word_length`, `Num_stop_bits` or `oversample_by_3` mid-frame do not affect the frame in flight.
- Effective data bits N:
  - `word_length`=0 gives N=8 (reset config yields 8N1).
  - 1..DATA_W gives N=`word_length`.
  - Greater than DATA_W gives N=DATA_W.
- Ticks per bit are OS=16 or OS=3. The tick counter counts only cycles with `tick`=1.
- A bit ends at the clock edge after the OS-th tick counted in that bit; the tick counter then clears.
- START: `txd`=0 for one bit period, then go to DATA.
- DATA:
  - `txd`=shift register bit 0; shift right at each bit end.
  - After N bits, go to STOP.
- STOP:
  - `txd`=1 for 1 or 2 bit periods, per the latched stop count.
  - Then go to IDLE and pulse `frame_done` for one cycle.
- `busy`=1 in START, DATA and STOP. `tx_ready` = (state==IDLE).
- `txd`, `busy` and `frame_done` are registered outputs.
- No parity bit. No other states.

## Timing
- Accept at edge E: `txd` falls and `busy` rises at edge E+1, regardless of tick phase.
- A `tick` in the acceptance cycle is not counted.
- Frame length is exactly (1+N+S)·OS ticks, with S = 1 or 2. The first bit may include extra non-tick cycles; tick counts are exact.
- `frame_done` is high for the one cycle in which state first becomes IDLE, and `tx_ready` is 1 in that same cycle.
  - Back-to-back: with `tx_valid` held, the next word is accepted in that cycle.
  - Minimum inter-frame gap is 1 clk of idle high.
- `tx_valid` while busy is ignored. The upstream must hold `tx_data` until accepted.
- Simultaneous tick and bit-end: the counter clears and the next bit starts; no tick is lost or double-counted.
- Reset mid-frame: `txd` goes to 1 asynchronously, the frame is discarded, and no `frame_done` pulse is produced.
- Back-to-back ticks (tick=1 every cycle) are legal; each bit then lasts exactly OS cycles.

## Test plan
- Reset config (`word_length`=0, one stop bit, OS=16), send 0xA5, tick every cycle:
  - `txd` = 0, 1,0,1,0,0,1,0,1, 1, each bit 16 cycles.
  - `frame_done` at cycle 161 after acceptance.
- `word_length`=5, `Num_stop_bits`=1, `oversample_by_3`=1, send 0x13, tick every 4th cycle:
  - `txd` = 0, 1,1,0,0,1, 1,1, each bit 3 ticks.
  - Total 24 ticks.
- Start 8N1 OS=16, then switch to `word_length`=6, two stop bits, OS=3 mid-DATA:
  - The current frame completes as 10 bits × 16 ticks.
  - The next accepted frame uses 6 data bits, 2 stop bits, 3 ticks per bit.
- `tx_valid` held high with words 0x01, 0x02, 0x03:
  - Three frames are sent.
  - Exactly one idle-high cycle separates them.
  - `tx_ready` is high only in the `frame_done` cycles.
- Assert `reset_n` low during DATA bit 3:
  - `txd`=1, `busy`=0 and `tx_ready`=1 immediately.
  - After release, a new 0x5A frame transmits correctly.
- DATA_W=16, `word_length`=20, send 0xBEEF:
  - 16 data bits, LSB first, are sent, followed by the stop bits.
- `word_length`=16, send 0xBEEF:
  - Output is identical to the `word_length`=20 case.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, one or two stop bits,
// with bit timing taken from an external oversample tick.
module uart_tx_serializer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic [4:0]        word_length,
  input  logic              Num_stop_bits,
  input  logic              oversample_by_3,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]     nbits_q, nbits_d;
  logic              two_stop_q, two_stop_d;
  logic              os3_q, os3_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic [BW-1:0]     nbits_eff;
  logic [3:0]        os_last;
  logic              bit_end;

  always_comb begin
    if (word_length == 5'd0)
      nbits_eff = BW'(8);
    else if (32'(word_length) > DATA_W)
      nbits_eff = BW'(DATA_W);
    else
      nbits_eff = BW'(word_length);
  end

  assign os_last  = os3_q ? 4'd2 : 4'd15;
  // In IDLE the tick counter is held at zero, so a tick in the acceptance cycle is never counted.
  assign bit_end  = (state_q != IDLE) && tick && (tick_cnt_q == os_last);
  assign tx_ready = (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    nbits_d    = nbits_q;
    two_stop_d = two_stop_q;
    os3_d      = os3_q;
    shreg_d    = shreg_q;

    if (state_q == IDLE)
      tick_cnt_d = '0;
    else if (bit_end)
      tick_cnt_d = '0;
    else if (tick)
      tick_cnt_d = tick_cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shreg_d    = tx_data;
          nbits_d    = nbits_eff;
          two_stop_d = Num_stop_bits;
          os3_d      = oversample_by_3;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == nbits_q - BW'(1)) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && (bit_cnt_q == '0))
            bit_cnt_d = BW'(1);
          else begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they move on the same edge as the FSM.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      nbits_q      <= '0;
      two_stop_q   <= 1'b0;
      os3_q        <= 1'b0;
      shreg_q      <= '0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      nbits_q      <= nbits_d;
      two_stop_q   <= two_stop_d;
      os3_q        <= os3_d;
      shreg_q      <= shreg_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer: frame bit patterns,
// tick-exact bit lengths, config latching, back-to-back frames and reset abort.
module tb_uart_tx_serializer;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              tick = 1'b0;
  logic [4:0]        word_length = '0;
  logic              Num_stop_bits = 1'b0;
  logic              oversample_by_3 = 1'b0;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_ready;
  logic              txd;
  logic              busy;
  logic              frame_done;

  int errors = 0;
  int checks = 0;
  int tick_period = 1;
  int tick_phase = 0;

  uart_tx_serializer #(.DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .tick            (tick),
    .word_length     (word_length),
    .Num_stop_bits   (Num_stop_bits),
    .oversample_by_3 (oversample_by_3),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .txd             (txd),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  // Tick changes just after the rising edge so it is stable when sampled at the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_phase = tick_phase + 1;
      tick = (tick_phase % tick_period) == 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [DATA_W-1:0] data, input logic [31:0] frame,
                      input int len, input int os, input bit hold,
                      input int chg_bit, input int exp_cyc, input string tag);
    int guard, cnt, cyc;
    bit ok;
    logic o_txd, o_busy, o_rdy;
    tx_data  = data;
    tx_valid = 1'b1;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    assert (tx_ready === 1'b1)
      else begin errors++; $error("FAIL %s accept: tx_ready=%b expected 1", tag, tx_ready); end
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    cyc = 0;
    for (int b = 0; b < len; b++) begin
      if (b == chg_bit) begin
        word_length = 5'd6; Num_stop_bits = 1'b1; oversample_by_3 = 1'b1;
      end
      ok = 1'b1; cnt = 0; guard = 0;
      o_txd = txd; o_busy = busy; o_rdy = tx_ready;
      while (cnt < os && guard < 1000) begin
        @(negedge clk);
        cyc++; guard++;
        if (ok && (txd !== frame[b] || busy !== 1'b1 || tx_ready !== 1'b0 || frame_done !== 1'b0)) begin
          ok = 1'b0; o_txd = txd; o_busy = busy; o_rdy = tx_ready;
        end
        if (tick) cnt++;
      end
      checks++;
      assert (ok && cnt == os)
        else begin
          errors++;
          $error("FAIL %s bit%0d: txd=%b busy=%b ready=%b ticks=%0d, expected txd=%b busy=1 ready=0 ticks=%0d",
                 tag, b, o_txd, o_busy, o_rdy, cnt, frame[b], os);
        end
    end
    @(negedge clk);
    cyc++;
    checks++;
    assert (frame_done === 1'b1 && tx_ready === 1'b1 && txd === 1'b1 && busy === 1'b0)
      else begin
        errors++;
        $error("FAIL %s done: frame_done=%b ready=%b txd=%b busy=%b expected 1 1 1 0",
               tag, frame_done, tx_ready, txd, busy);
      end
    if (exp_cyc > 0) begin
      checks++;
      assert (cyc == exp_cyc)
        else begin errors++; $error("FAIL %s length: done at cycle %0d expected %0d", tag, cyc, exp_cyc); end
    end
    if (!hold) begin
      @(negedge clk);
      checks++;
      assert (frame_done === 1'b0 && txd === 1'b1 && busy === 1'b0)
        else begin
          errors++;
          $error("FAIL %s idle: frame_done=%b txd=%b busy=%b expected 0 1 0", tag, frame_done, txd, busy);
        end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    assert (txd === 1'b1 && tx_ready === 1'b1 && busy === 1'b0 && frame_done === 1'b0)
      else begin
        errors++;
        $error("FAIL reset: txd=%b ready=%b busy=%b done=%b expected 1 1 0 0", txd, tx_ready, busy, frame_done);
      end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 at 16x, tick every cycle
    tick_period = 1;
    send(16'h00A5, {1'b1, 8'hA5, 1'b0}, 10, 16, 1'b0, -1, 161, "a5_8n1");

    // 5 data bits, 2 stop bits, 3x, tick every 4th cycle
    word_length = 5'd5; Num_stop_bits = 1'b1; oversample_by_3 = 1'b1;
    tick_period = 4;
    send(16'h0013, {2'b11, 5'h13, 1'b0}, 8, 3, 1'b0, -1, 0, "13_5n2_os3");

    // Config switched mid-DATA applies only to the next frame
    tick_period = 1;
    word_length = 5'd0; Num_stop_bits = 1'b0; oversample_by_3 = 1'b0;
    send(16'h003C, {1'b1, 8'h3C, 1'b0}, 10, 16, 1'b0, 3, 161, "3c_midchange");
    send(16'hFFAD, {2'b11, 6'h2D, 1'b0}, 9, 3, 1'b0, -1, 28, "2d_6n2_os3");

    // Back-to-back with tx_valid held
    word_length = 5'd0; Num_stop_bits = 1'b0; oversample_by_3 = 1'b0;
    send(16'h0001, {1'b1, 8'h01, 1'b0}, 10, 16, 1'b1, -1, 161, "b2b_01");
    send(16'h0002, {1'b1, 8'h02, 1'b0}, 10, 16, 1'b1, -1, 161, "b2b_02");
    send(16'h0003, {1'b1, 8'h03, 1'b0}, 10, 16, 1'b1, -1, 161, "b2b_03");
    tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    assert (frame_done === 1'b0 && txd === 1'b1 && busy === 1'b0 && tx_ready === 1'b1)
      else begin
        errors++;
        $error("FAIL b2b_end: done=%b txd=%b busy=%b ready=%b expected 0 1 0 1", frame_done, txd, busy, tx_ready);
      end

    // Reset asserted during DATA bit 3 (0x77 bit 3 is 0)
    tx_data = 16'h0077; tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (70) @(negedge clk);
    checks++;
    assert (txd === 1'b0 && busy === 1'b1)
      else begin errors++; $error("FAIL pre_abort: txd=%b busy=%b expected 0 1", txd, busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    assert (txd === 1'b1 && busy === 1'b0 && tx_ready === 1'b1)
      else begin
        errors++;
        $error("FAIL async_reset: txd=%b busy=%b ready=%b expected 1 0 1", txd, busy, tx_ready);
      end
    repeat (3) begin
      @(negedge clk);
      checks++;
      assert (frame_done === 1'b0 && txd === 1'b1)
        else begin errors++; $error("FAIL in_reset: done=%b txd=%b expected 0 1", frame_done, txd); end
    end
    reset_n = 1'b1;
    @(negedge clk);
    send(16'h005A, {1'b1, 8'h5A, 1'b0}, 10, 16, 1'b0, -1, 161, "5a_after_reset");

    // Oversized word length clamps to DATA_W
    word_length = 5'd20;
    send(16'hBEEF, {1'b1, 16'hBEEF, 1'b0}, 18, 16, 1'b0, -1, 289, "beef_wl20");
    word_length = 5'd16;
    send(16'hBEEF, {1'b1, 16'hBEEF, 1'b0}, 18, 16, 1'b0, -1, 289, "beef_wl16");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
